// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage between execute and writeback.
// Registers execute outputs (M), runs LDR/STR word/byte over a req/ack
// handshake with a bounded wait, and produces the writeback triple.
// Ports:
//   clk_i, reset_i      clock, synchronous active-low reset
//   inst_i..valid_i     execute outputs captured into M when not stalled
//   stall_o             hold execute while an access is outstanding
//   mem_*               data memory request/response
//   wb_*, valid_o,
//   inst_o              registered writeback outputs
//   err_o               sticky access-timeout flag
module mem_access #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] alu_data_i,
    input  logic [31:0] rd_data_i,
    input  logic [3:0]  rd_addr_i,
    input  logic        do_write_i,
    input  logic        valid_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic [31:0] wb_data_o,
    output logic [3:0]  wb_addr_o,
    output logic        wb_en_o,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic        err_o
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0] m_inst_q;
    logic [31:0] m_alu_q;
    logic [31:0] m_rdd_q;
    logic [3:0]  m_rda_q;
    logic        m_dw_q;
    logic        m_valid_q;

    logic [31:0] wb_data_q;
    logic [3:0]  wb_addr_q;
    logic        wb_en_q;
    logic        valid_q;
    logic [31:0] inst_q;
    logic        err_q;

    logic        access;
    logic        is_mem;
    logic        is_load;
    logic        is_byte;
    logic [1:0]  lane;
    logic        abort;
    logic        stall;
    logic        complete;
    logic        in_is_mem;
    logic [5:0]  sh;
    logic [31:0] load_word;
    logic [31:0] load_data;
    logic [31:0] wb_data_d;
    logic        wb_en_d;

    assign access    = (state_q == ACCESS);
    assign is_mem    = m_valid_q && (m_inst_q[27:26] == 2'b01);
    assign is_load   = m_inst_q[20];
    assign is_byte   = m_inst_q[22];
    assign lane      = m_alu_q[1:0];
    assign in_is_mem = valid_i && (inst_i[27:26] == 2'b01);

    assign abort    = access && !mem_ack_i && (cnt_q == CW'(MAX_WAIT - 1));
    assign stall    = access && !mem_ack_i && !abort;
    // M retires whenever execute is allowed to advance.
    assign complete = !stall;

    // Unaligned word load: rotate right by the byte lane.
    // A shift by 32 yields zero, so lane 0 passes through unrotated.
    assign sh        = {1'b0, lane, 3'b000};
    assign load_word = (mem_rdata_i >> sh) | (mem_rdata_i << (6'd32 - sh));
    assign load_data = is_byte ? {24'b0, mem_rdata_i[{lane, 3'b000} +: 8]}
                               : load_word;

    assign wb_en_d   = m_valid_q && m_dw_q && !(is_mem && !is_load) && !abort;
    assign wb_data_d = (is_mem && is_load) ? load_data : m_alu_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (complete) begin
            state_d = in_is_mem ? ACCESS : IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            m_inst_q  <= '0;
            m_alu_q   <= '0;
            m_rdd_q   <= '0;
            m_rda_q   <= '0;
            m_dw_q    <= 1'b0;
            m_valid_q <= 1'b0;
            wb_data_q <= '0;
            wb_addr_q <= '0;
            wb_en_q   <= 1'b0;
            valid_q   <= 1'b0;
            inst_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (complete) begin
                m_inst_q  <= inst_i;
                m_alu_q   <= alu_data_i;
                m_rdd_q   <= rd_data_i;
                m_rda_q   <= rd_addr_i;
                m_dw_q    <= do_write_i;
                m_valid_q <= valid_i;
                wb_data_q <= wb_data_d;
                wb_addr_q <= m_rda_q;
                wb_en_q   <= wb_en_d;
                valid_q   <= m_valid_q;
                inst_q    <= m_inst_q;
            end
            if (abort) begin
                err_q <= 1'b1;
            end
        end
    end

    assign stall_o     = stall;
    assign mem_req_o   = access;
    assign mem_we_o    = access && !is_load;
    assign mem_addr_o  = access ? {m_alu_q[31:2], 2'b00} : 32'b0;
    assign mem_be_o    = !access ? 4'b0000
                       : is_byte ? (4'b0001 << lane)
                       : 4'b1111;
    assign mem_wdata_o = !access ? 32'b0
                       : is_byte ? {4{m_rdd_q[7:0]}}
                       : m_rdd_q;

    assign wb_data_o = wb_data_q;
    assign wb_addr_o = wb_addr_q;
    assign wb_en_o   = wb_en_q;
    assign valid_o   = valid_q;
    assign inst_o    = inst_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: random + directed bench for mem_access
// against a transaction-level model with a behavioural memory.
module tb_mem_access;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] inst_i, alu_data_i, rd_data_i;
  logic [3:0]  rd_addr_i;
  logic        do_write_i, valid_i;
  logic        stall_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic [31:0] wb_data_o;
  logic [3:0]  wb_addr_o;
  logic        wb_en_o, valid_o;
  logic [31:0] inst_o;
  logic        err_o;

  always #5 clk = ~clk;

  mem_access #(.MAX_WAIT(MW)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .inst_i(inst_i), .alu_data_i(alu_data_i),
    .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i),
    .do_write_i(do_write_i), .valid_i(valid_i),
    .stall_o(stall_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .wb_data_o(wb_data_o), .wb_addr_o(wb_addr_o),
    .wb_en_o(wb_en_o), .valid_o(valid_o),
    .inst_o(inst_o), .err_o(err_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mem_m [0:1023];

  logic [31:0] c_inst, c_alu, c_rdd;
  logic [3:0]  c_rda;
  logic        c_dw, c_v;
  int          waited, c_delay, force_delay;

  logic [31:0] e_data, e_inst;
  logic [3:0]  e_addr;
  logic        e_en, e_valid, e_err;
  logic        acc;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    c_inst = '0; c_alu = '0; c_rdd = '0; c_rda = '0;
    c_dw = 0; c_v = 0; waited = 0; c_delay = 0;
    e_data = '0; e_inst = '0; e_addr = '0;
    e_en = 0; e_valid = 0; e_err = 0;
  endtask

  task automatic check_out(input string ph);
    check({ph, "_valid"}, valid_o, e_valid);
    check({ph, "_inst"}, inst_o, e_inst);
    check({ph, "_wbaddr"}, wb_addr_o, e_addr);
    check({ph, "_wben"}, wb_en_o, e_en);
    check({ph, "_wbdata"}, wb_data_o, e_data);
    check({ph, "_err"}, err_o, e_err);
  endtask

  // One clock: entered just after a negedge with inputs driven.
  task automatic cycle();
    logic ack, abrt, st, ld, by, mm;
    logic [1:0]  ln;
    logic [31:0] rd, lw;
    mm = c_v && (c_inst[27:26] == 2'b01);
    ld = c_inst[20];
    by = c_inst[22];
    ln = c_alu[1:0];
    ack = mm && (waited == c_delay);
    rd = (ack && ld) ? mem_m[c_alu[11:2]] : $urandom;
    abrt = mm && !ack && (waited == MW - 1);
    st = mm && !ack && !abrt;
    mem_ack_i = ack;
    mem_rdata_i = rd;
    #1;
    check("stall", stall_o, st);
    check("req", mem_req_o, mm);
    if (mm) begin
      check("we", mem_we_o, !ld);
      check("addr", mem_addr_o, c_alu & 32'hFFFF_FFFC);
      check("be", mem_be_o, by ? (4'b0001 << ln) : 4'hF);
      if (!ld)
        check("wdata", mem_wdata_o,
              by ? {24'b0, c_rdd[7:0]} * 32'h0101_0101 : c_rdd);
    end
    @(posedge clk);
    acc = !st;
    if (st) begin
      waited++;
    end else begin
      for (int j = 0; j < 4; j++)
        lw[8*j +: 8] = rd[8*((j + ln) % 4) +: 8];
      if (by) lw = {24'b0, lw[7:0]};
      e_valid = c_v;
      e_inst  = c_inst;
      e_addr  = c_rda;
      e_en    = c_v && c_dw && !(mm && !ld) && !abrt;
      e_data  = (mm && ld) ? lw : c_alu;
      if (abrt) e_err = 1;
      if (ack && !ld) begin
        if (by) mem_m[c_alu[11:2]][8*ln +: 8] = c_rdd[7:0];
        else    mem_m[c_alu[11:2]] = c_rdd;
      end
      c_inst = inst_i; c_alu = alu_data_i; c_rdd = rd_data_i;
      c_rda = rd_addr_i; c_dw = do_write_i; c_v = valid_i;
      waited = 0;
      c_delay = (force_delay >= 0) ? force_delay
                                   : int'($urandom_range(0, MW));
    end
    #1;
    check_out("out");
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] in, a, d,
                       input logic [3:0] r,
                       input logic dw, v,
                       input int dly);
    inst_i = in; alu_data_i = a; rd_data_i = d;
    rd_addr_i = r; do_write_i = dw; valid_i = v;
    force_delay = dly;
    acc = 0;
    for (int k = 0; k < MW + 2 && !acc; k++) cycle();
  endtask

  task automatic bubble();
    issue(32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 0);
  endtask

  task automatic rand_in();
    logic [31:0] in;
    in = $urandom;
    if ($urandom_range(0, 1) == 0) begin
      in[27] = 1'($urandom);
      in[26] = in[27] ? 1'($urandom) : 1'b0;
      alu_data_i = $urandom;
    end else begin
      in[27:26] = 2'b01;
      alu_data_i = $urandom_range(0, 4095);
    end
    inst_i = in;
    rd_data_i = $urandom;
    rd_addr_i = 4'($urandom);
    do_write_i = 1'($urandom);
    valid_i = ($urandom_range(0, 5) != 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_m[i] = $urandom;
    model_reset();
    force_delay = -1;
    reset_i = 0;
    inst_i = '0; alu_data_i = '0; rd_data_i = '0;
    rd_addr_i = '0; do_write_i = 0; valid_i = 0;
    mem_ack_i = 0; mem_rdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", mem_req_o, 0);
    check("rst_stall", stall_o, 0);
    check_out("rst");
    @(negedge clk);
    reset_i = 1;

    issue(32'hE080_0000, 32'h42, 32'h0, 4'd3, 1, 1, 0);
    bubble();
    check("add_data", wb_data_o, 32'h42);
    check("add_addr", wb_addr_o, 4'd3);
    check("add_en", wb_en_o, 1);

    mem_m[32'h100 >> 2] = 32'hDEAD_BEEF;
    issue(32'hE590_0000, 32'h100, 32'h0, 4'd5, 1, 1, 0);
    bubble();
    check("ldr_data", wb_data_o, 32'hDEAD_BEEF);

    mem_m[32'h100 >> 2] = 32'h1122_3344;
    issue(32'hE5D0_0000, 32'h102, 32'h0, 4'd6, 1, 1, 3);
    bubble();
    check("ldrb_data", wb_data_o, 32'h0000_0022);

    issue(32'hE5C0_0000, 32'h201, 32'hAB, 4'd7, 1, 1, 0);
    bubble();
    check("strb_en", wb_en_o, 0);
    check("strb_valid", valid_o, 1);

    mem_m[32'h300 >> 2] = 32'h1122_3344;
    issue(32'hE590_0000, 32'h301, 32'h0, 4'd8, 1, 1, 0);
    bubble();
    check("ldr_rot", wb_data_o, 32'h4411_2233);

    issue(32'hE590_0000, 32'h100, 32'h0, 4'd9, 1, 1, MW);
    bubble();
    check("to_err", err_o, 1);
    check("to_en", wb_en_o, 0);

    force_delay = -1;
    for (int n = 0; n < 3000; n++) begin
      rand_in();
      cycle();
    end

    issue(32'hE590_0000, 32'h40, 32'h0, 4'd2, 1, 1, MW);
    inst_i = '0; valid_i = 0;
    reset_i = 0;
    mem_ack_i = 0;
    @(posedge clk);
    #1;
    model_reset();
    check("mrst_req", mem_req_o, 0);
    check("mrst_stall", stall_o, 0);
    check_out("mrst");
    @(negedge clk);
    reset_i = 1;
    force_delay = -1;
    for (int n = 0; n < 300; n++) begin
      rand_in();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Pipeline stage directly downstream of execute, upstream of register-file writeback.
- Registers execute's outputs, performs LDR/STR (word/byte) to data memory over a req/ack handshake, and produces the writeback triple.
- Back-pressures execute with stall_o while a memory access is outstanding; aborts an access after a bounded wait.

Parameters:
MAX_WAIT, 16, max cycles a request stays in ACCESS without mem_ack_i before abort (>=1)

Ports:
clk_i  in  1  clock, all state on rising edge
reset_i  in  1  synchronous reset, active-low
inst_i  in  32  instruction from execute
alu_data_i  in  32  ALU result / effective address from execute
rd_data_i  in  32  store data from execute
rd_addr_i  in  4  destination register from execute
do_write_i  in  1  register write request from execute
valid_i  in  1  execute output valid
stall_o  out  1  hold execute outputs this cycle
mem_req_o  out  1  memory request
mem_we_o  out  1  1=store, 0=load
mem_addr_o  out  32  word address {alu[31:2],2'b00}
mem_wdata_o  out  32  store data
mem_be_o  out  4  byte enables
mem_rdata_i  in  32  load data, valid with mem_ack_i
mem_ack_i  in  1  request complete this cycle
wb_data_o  out  32  writeback data
wb_addr_o  out  4  writeback register
wb_en_o  out  1  writeback enable
valid_o  out  1  instruction in writeback valid
inst_o  out  32  instruction in writeback
err_o  out  1  sticky: a memory access timed out

Behaviour:
- Reset (reset_i==0 at an edge): state=IDLE, wait counter=0, M register cleared (valid=0), all outputs 0, err_o=0. Reset mid-ACCESS drops mem_req_o after that edge; no writeback is produced for the aborted access.
- Capture: on each edge with stall_o==0, M <= {inst_i, alu_data_i, rd_data_i, rd_addr_i, do_write_i, valid_i}. With stall_o==1, M holds.
- Classify M: is_mem = M.valid && inst[27:26]==2'b01; is_load = inst[20]; is_byte = inst[22]; lane = alu[1:0].
- FSM IDLE/ACCESS:
  - IDLE: a capture of an is_mem instruction moves to ACCESS on the same edge; counter=0.
  - ACCESS: mem_req_o=1; mem_we_o=~is_load; addr/wdata/be held stable until ack or abort.
  - ACCESS + mem_ack_i: M completes; next edge -> IDLE, or straight back to ACCESS if the newly captured instruction is_mem (back-to-back, no bubble).
  - ACCESS, no ack, counter==MAX_WAIT-1: abort; M completes with wb_en forced 0; err_o<=1 (sticky). Otherwise counter+1.
- stall_o = (state==ACCESS) && !mem_ack_i && !abort. Combinational, so execute advances in the ack/abort cycle.
- Completion: M completes in the cycle it is in IDLE (non-mem or invalid) or the ack/abort cycle. Output registers load on that edge; otherwise outputs hold.
  - Latency: non-mem 1 cycle M->outputs; load/store 1+N where N = wait cycles before ack.
- Outputs on completion:
  - valid_o=M.valid; inst_o=M.inst; wb_addr_o=M.rd_addr.
  - wb_en_o = M.valid && M.do_write && !(is_mem && !is_load) && !abort.
  - wb_data_o = is_mem&&is_load ? load_data : M.alu.
- Load data:
  - Byte: zero-extend mem_rdata_i[8*lane+:8].
  - Word: mem_rdata_i rotated right by 8*lane (lane 0 = unrotated).
- Store:
  - Word: be=4'b1111, wdata=M.rd_data.
  - Byte: be=4'b0001<<lane, wdata={4{M.rd_data[7:0]}}.
- Invalid M (valid=0) never asserts mem_req_o; it produces valid_o=0, wb_en_o=0.
- Base-register writeback (W/post-index) is not performed by this block.

Test Plan:
- ADD result alu=0x0000_0042, rd=3, do_write=1 -> next edge wb_data_o=0x42, wb_addr_o=3, wb_en_o=1, stall_o never high.
- LDR word, alu=0x100, ack in the first ACCESS cycle with rdata=0xDEAD_BEEF -> mem_addr_o=0x100, be=0xF, stall_o=0, wb_data_o=0xDEADBEEF one cycle later.
- LDRB alu=0x102, ack after 3 wait cycles, rdata=0x1122_3344 -> stall_o high 3 cycles, execute held, wb_data_o=0x0000_0022.
- STRB alu=0x201, rd_data=0x0000_00AB -> mem_we_o=1, addr=0x200, be=4'b0010, wdata=0xABAB_ABAB, wb_en_o=0, valid_o=1.
- Unaligned LDR alu=0x301, rdata=0x1122_3344 -> wb_data_o=0x4411_2233.
- MAX_WAIT=4, no ack -> 4 request cycles, then abort: err_o=1 stays high, wb_en_o=0, stall_o drops. Separately, reset_i=0 during ACCESS -> mem_req_o=0 after the edge, all outputs 0.
